upd_phy_iq_noise_packer: RTL and testbench

Writer-side companion of the slow-PHY LLR front end. It accepts per-strobe RE-pair IQ samples and noise samples from the equalizer path and packs them into 128-bit words (8 × 16-bit lanes). It pushes those words into the IQ FIFO and the Noise FIFO that the slow-PHY-to-LLR reader drains. It applies the same per-user RE count and IQ/noise rate the reader uses, so both ends agree on word counts and zero padding.

---
 rtl/upd_phy_iq_noise_packer.sv | 148 ++++++++++++++
 tb/tb_upd_phy_iq_noise_packer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/upd_phy_iq_noise_packer.sv
// upd_phy_iq_noise_packer: packs per-strobe IQ RE pairs and decimated noise samples into 128-bit FIFO words
module upd_phy_iq_noise_packer #(
   parameter int LANES = 8
) (
   input  logic                  i_core_clk,
   input  logic                  i_rx_rstn,
   input  logic                  i_start,
   input  logic [15:0]           i_user_iq_noise_rate,
   input  logic [15:0]           i_cur_user_re_amounts,
   input  logic                  i_data_strobe,
   input  logic [15:0]           i_re0_data_i,
   input  logic [15:0]           i_re0_data_q,
   input  logic [15:0]           i_re1_data_i,
   input  logic [15:0]           i_re1_data_q,
   input  logic [15:0]           i_noise_data,
   input  logic                  IQ_FIFO_Full,
   input  logic                  Noise_FIFO_Full,
   output logic                  o_ready,
   output logic                  IQ_FIFO_Write_Enable,
   output logic                  Noise_FIFO_Write_Enable,
   output logic [16*LANES-1:0]   IQ_FIFO_Write_Data,
   output logic [16*LANES-1:0]   Noise_FIFO_Write_Data,
   output logic                  o_busy,
   output logic                  o_done
);
   localparam int W = 16 * LANES;
   localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2, DONE = 2'd3;

   logic [1:0]     state_q, state_d;
   logic [15:0]    rate_q, rate_d, strobes_q, strobes_d, beat_q, beat_d, rcnt_q, rcnt_d;
   logic           odd_q, odd_d;
   logic           iq_half_q, iq_half_d, iq_pend_q, iq_pend_d;
   logic [W/2-1:0] iq_asm_q, iq_asm_d;
   logic [W-1:0]   iq_out_q, iq_out_d;
   logic [2:0]     nz_lane_q, nz_lane_d;
   logic           nz_pend_q, nz_pend_d;
   logic [W-1:0]   nz_asm_q, nz_asm_d, nz_out_q, nz_out_d, nz_ins;
   logic [16:0]    re_p1;
   logic [W/2-1:0] beat_lanes;
   logic           acc, last, cap, iq_cmp, nz_cmp, iq_fl, nz_fl;

   assign IQ_FIFO_Write_Enable    = iq_pend_q & ~IQ_FIFO_Full;
   assign Noise_FIFO_Write_Enable = nz_pend_q & ~Noise_FIFO_Full;
   assign IQ_FIFO_Write_Data      = iq_out_q;
   assign Noise_FIFO_Write_Data   = nz_out_q;
   assign o_busy                  = state_q != IDLE;
   assign o_done                  = state_q == DONE;
   assign o_ready    = (state_q == RUN) & ~(iq_pend_q & IQ_FIFO_Full) & ~(nz_pend_q & Noise_FIFO_Full);
   assign acc        = i_data_strobe & o_ready;
   assign last       = beat_q == strobes_q - 16'd1;
   assign cap        = acc & (rcnt_q == 16'd0);
   assign iq_cmp     = acc & iq_half_q;
   assign nz_cmp     = cap & (nz_lane_q == 3'd7);
   assign iq_fl      = (state_q == FLUSH) & iq_half_q & (~iq_pend_q | IQ_FIFO_Write_Enable);
   assign nz_fl      = (state_q == FLUSH) & (nz_lane_q != 3'd0) & (~nz_pend_q | Noise_FIFO_Write_Enable);
   assign re_p1      = {1'b0, i_cur_user_re_amounts} + 17'd1;
   assign beat_lanes = {(last & odd_q) ? 32'd0 : {i_re1_data_q, i_re1_data_i}, i_re0_data_q, i_re0_data_i};

   // current noise assembly word with this beat's sample dropped into the next free lane
   always_comb begin
      nz_ins = nz_asm_q;
      nz_ins[{nz_lane_q, 4'd0} +: 16] = i_noise_data;
   end

   // next-state: user setup, beat packing, flush of partial words and output register handoff
   always_comb begin
      state_d   = state_q;
      rate_d    = rate_q;
      strobes_d = strobes_q;
      odd_d     = odd_q;
      beat_d    = beat_q;
      rcnt_d    = rcnt_q;
      iq_half_d = iq_half_q;
      iq_asm_d  = iq_asm_q;
      nz_lane_d = nz_lane_q;
      nz_asm_d  = nz_asm_q;
      if (state_q == IDLE && i_start) begin
         rate_d    = (i_user_iq_noise_rate == 16'd0) ? 16'd1 : i_user_iq_noise_rate;
         strobes_d = re_p1[16:1];
         odd_d     = i_cur_user_re_amounts[0];
         beat_d    = 16'd0;
         rcnt_d    = 16'd0;
         iq_half_d = 1'b0;
         nz_lane_d = 3'd0;
         nz_asm_d  = '0;
         state_d   = (i_cur_user_re_amounts == 16'd0) ? DONE : RUN;
      end
      if (acc) begin
         beat_d    = beat_q + 16'd1;
         rcnt_d    = (rcnt_q == rate_q - 16'd1) ? 16'd0 : rcnt_q + 16'd1;
         iq_half_d = ~iq_half_q;
         iq_asm_d  = iq_half_q ? iq_asm_q : beat_lanes;
         state_d   = last ? FLUSH : state_q;
      end
      if (cap) begin
         nz_lane_d = nz_lane_q + 3'd1;
         nz_asm_d  = nz_cmp ? '0 : nz_ins;
      end
      if (iq_fl) iq_half_d = 1'b0;
      if (nz_fl) begin
         nz_lane_d = 3'd0;
         nz_asm_d  = '0;
      end
      if (state_q == FLUSH && !iq_half_q && nz_lane_q == 3'd0 &&
          (!iq_pend_q || IQ_FIFO_Write_Enable) && (!nz_pend_q || Noise_FIFO_Write_Enable))
         state_d = DONE;
      if (state_q == DONE) state_d = IDLE;
      iq_out_d  = iq_cmp ? {beat_lanes, iq_asm_q} : iq_fl ? {{(W/2){1'b0}}, iq_asm_q} : iq_out_q;
      iq_pend_d = iq_cmp | iq_fl | (iq_pend_q & ~IQ_FIFO_Write_Enable);
      nz_out_d  = nz_cmp ? nz_ins : nz_fl ? nz_asm_q : nz_out_q;
      nz_pend_d = nz_cmp | nz_fl | (nz_pend_q & ~Noise_FIFO_Write_Enable);
   end

   // state registers, cleared asynchronously so partial and pending words are dropped on reset
   always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
      if (!i_rx_rstn) begin
         state_q   <= IDLE;
         rate_q    <= 16'd1;
         strobes_q <= '0;
         odd_q     <= 1'b0;
         beat_q    <= '0;
         rcnt_q    <= '0;
         iq_half_q <= 1'b0;
         iq_asm_q  <= '0;
         iq_out_q  <= '0;
         iq_pend_q <= 1'b0;
         nz_lane_q <= '0;
         nz_asm_q  <= '0;
         nz_out_q  <= '0;
         nz_pend_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         rate_q    <= rate_d;
         strobes_q <= strobes_d;
         odd_q     <= odd_d;
         beat_q    <= beat_d;
         rcnt_q    <= rcnt_d;
         iq_half_q <= iq_half_d;
         iq_asm_q  <= iq_asm_d;
         iq_out_q  <= iq_out_d;
         iq_pend_q <= iq_pend_d;
         nz_lane_q <= nz_lane_d;
         nz_asm_q  <= nz_asm_d;
         nz_out_q  <= nz_out_d;
         nz_pend_q <= nz_pend_d;
      end
   end
endmodule

// File: tb/tb_upd_phy_iq_noise_packer.sv
// tb_upd_phy_iq_noise_packer: directed scenario tests of the IQ/noise FIFO word packer
module tb_upd_phy_iq_noise_packer;
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         i_start = 1'b0;
   logic [15:0]  rate_in = '0, re_in = '0;
   logic         strobe = 1'b0;
   logic [15:0]  r0i = '0, r0q = '0, r1i = '0, r1q = '0, nz = '0;
   logic         iq_full = 1'b0, nz_full = 1'b0;
   logic         o_ready, iq_we, nz_we, o_busy, o_done;
   logic [127:0] iq_wd, nz_wd;
   int           total = 0, bad = 0;

   always #5 clk = ~clk;

   upd_phy_iq_noise_packer dut (
      .i_core_clk(clk), .i_rx_rstn(rst_n), .i_start(i_start),
      .i_user_iq_noise_rate(rate_in), .i_cur_user_re_amounts(re_in),
      .i_data_strobe(strobe), .i_re0_data_i(r0i), .i_re0_data_q(r0q),
      .i_re1_data_i(r1i), .i_re1_data_q(r1q), .i_noise_data(nz),
      .IQ_FIFO_Full(iq_full), .Noise_FIFO_Full(nz_full), .o_ready(o_ready),
      .IQ_FIFO_Write_Enable(iq_we), .Noise_FIFO_Write_Enable(nz_we),
      .IQ_FIFO_Write_Data(iq_wd), .Noise_FIFO_Write_Data(nz_wd),
      .o_busy(o_busy), .o_done(o_done));

   // lane j of beat k for a given user tag; j=4 is the noise sample
   function automatic logic [15:0] lane_v(input int tag, input int k, input int j);
      return 16'(tag * 'h1000 + j * 'h0100 + k + 'h0C);
   endfunction

   task automatic drive_beat(input int tag, input int k);
      r0i = lane_v(tag, k, 0); r0q = lane_v(tag, k, 1);
      r1i = lane_v(tag, k, 2); r1q = lane_v(tag, k, 3); nz = lane_v(tag, k, 4);
   endtask

   task automatic outputs_zero(input string nm);
      total++;
      if ({o_ready, iq_we, nz_we, o_busy, o_done} !== 5'b0 || iq_wd !== '0 || nz_wd !== '0) begin
         bad++;
         $display("FAIL %s: ctl=%b iq=%h nz=%h required all 0", nm, {o_ready, iq_we, nz_we, o_busy, o_done}, iq_wd, nz_wd);
      end
   endtask

   // one full user: builds the expected words, drives beats, scoreboards every FIFO write
   task automatic run_user(input int tag, input int re, input int rate, input int iq_lo,
                           input int iq_hi, input int nz_len, input string nm);
      logic [127:0] exp_iq[$], exp_nz[$], got_iq[$], got_nz[$];
      logic [127:0] w;
      int s, reff, idx, k, lastc, done_c, done_n, lastw, lastnz;
      bit fin;
      s = (re + 1) / 2; reff = (rate == 0) ? 1 : rate;
      for (int wi = 0; wi < (s + 1) / 2; wi++) begin
         w = '0;
         for (int h = 0; h < 2; h++) begin
            int kk;
            kk = 2 * wi + h;
            if (kk < s) begin
               w[64*h +: 16] = lane_v(tag, kk, 0);
               w[64*h+16 +: 16] = lane_v(tag, kk, 1);
               if (!(kk == s - 1 && re % 2 == 1)) begin
                  w[64*h+32 +: 16] = lane_v(tag, kk, 2);
                  w[64*h+48 +: 16] = lane_v(tag, kk, 3);
               end
            end
         end
         exp_iq.push_back(w);
      end
      w = '0; idx = 0;
      for (int kk = 0; kk < s; kk += reff) begin
         w[16*(idx%8) +: 16] = lane_v(tag, kk, 4);
         idx++;
         if (idx % 8 == 0) begin exp_nz.push_back(w); w = '0; end
      end
      if (idx % 8 != 0) exp_nz.push_back(w);
      k = 0; lastc = -1; done_c = -1; done_n = 0; lastw = -1; lastnz = -1; fin = 0;
      rate_in = 16'(rate); re_in = 16'(re); i_start = 1'b1;
      for (int c = 0; c < 1000 && !fin; c++) begin
         if (c > 0) i_start = 1'b0;
         strobe = (c > 0 && k < s);
         if (k < s) drive_beat(tag, k);
         iq_full = (c >= iq_lo && c < iq_hi);
         nz_full = (lastc >= 0 && c > lastc && c <= lastc + nz_len);
         @(negedge clk);
         if (iq_we) begin got_iq.push_back(iq_wd); lastw = c; end
         if (nz_we) begin got_nz.push_back(nz_wd); lastw = c; lastnz = c; end
         total++;
         if ((iq_we && iq_full) || (nz_we && nz_full)) begin
            bad++; $display("FAIL %s we_vs_full c=%0d: iq_we=%b iq_full=%b nz_we=%b nz_full=%b required no write while full", nm, c, iq_we, iq_full, nz_we, nz_full);
         end
         if (c == 1) begin
            total++;
            if (o_busy !== 1'b1) begin bad++; $display("FAIL %s busy_after_start: got %b required 1", nm, o_busy); end
         end
         if (c > 0 && k < s) begin
            total++;
            if (!o_ready && !iq_full && !nz_full) begin
               bad++; $display("FAIL %s ready c=%0d: got 0 required 1 with no FIFO full", nm, c);
            end
         end
         if (strobe && o_ready) begin k++; if (k == s) lastc = c; end
         if (o_done) begin done_n++; done_c = c; end
         @(posedge clk); #1;
         if (done_n > 0 && c >= done_c + 3) fin = 1;
      end
      strobe = 1'b0; iq_full = 1'b0; nz_full = 1'b0;
      total++;
      if (!fin) begin bad++; $display("FAIL %s timeout: o_done seen %0d times, required 1 within budget", nm, done_n); end
      total++;
      if (done_n != 1) begin bad++; $display("FAIL %s done_pulses: got %0d required 1", nm, done_n); end
      total++;
      if (done_c <= lastw) begin bad++; $display("FAIL %s done_order: done at %0d last write %0d, required done after writes", nm, done_c, lastw); end
      total++;
      if (got_iq.size() != exp_iq.size()) begin bad++; $display("FAIL %s iq_count: got %0d required %0d", nm, got_iq.size(), exp_iq.size()); end
      total++;
      if (got_nz.size() != exp_nz.size()) begin bad++; $display("FAIL %s nz_count: got %0d required %0d", nm, got_nz.size(), exp_nz.size()); end
      for (int i = 0; i < exp_iq.size() && i < got_iq.size(); i++) begin
         total++;
         if (got_iq[i] !== exp_iq[i]) begin bad++; $display("FAIL %s iq_word%0d: got %h required %h", nm, i, got_iq[i], exp_iq[i]); end
      end
      for (int i = 0; i < exp_nz.size() && i < got_nz.size(); i++) begin
         total++;
         if (got_nz[i] !== exp_nz[i]) begin bad++; $display("FAIL %s nz_word%0d: got %h required %h", nm, i, got_nz[i], exp_nz[i]); end
      end
      if (re == 0) begin
         total++;
         if (done_c < 1 || done_c > 2) begin bad++; $display("FAIL %s done_latency: got cycle %0d required within 2 of start", nm, done_c); end
      end
      if (nz_len > 0) begin
         total++;
         if (lastnz != lastc + nz_len + 1) begin bad++; $display("FAIL %s nz_held_write: got cycle %0d required %0d", nm, lastnz, lastc + nz_len + 1); end
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      repeat (3) @(posedge clk);
      #1;
      outputs_zero("reset_values");
      rst_n = 1'b1;
      @(posedge clk); #1;
      outputs_zero("idle_after_release");
   endtask

   task automatic test_basic;
      run_user(1, 107, 6, -1, -1, 0, "re107_rate6");
   endtask

   task automatic test_exact_fill;
      run_user(2, 16, 1, -1, -1, 0, "re16_rate1");
   endtask

   task automatic test_backpressure;
      run_user(3, 40, 3, 5, 25, 0, "iq_backpressure");
   endtask

   task automatic test_noise_full_flush;
      run_user(4, 20, 2, -1, -1, 6, "noise_full_flush");
   endtask

   task automatic test_zero_cases;
      run_user(7, 0, 4, -1, -1, 0, "re0");
      run_user(8, 6, 0, -1, -1, 0, "rate0");
   endtask

   task automatic test_reset_mid;
      rate_in = 16'd2; re_in = 16'd40; i_start = 1'b1; iq_full = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
      for (int k = 0; k < 6; k++) begin
         strobe = 1'b1; drive_beat(5, k);
         @(posedge clk); #1;
      end
      @(negedge clk);
      total++;
      if (o_ready !== 1'b0 || iq_wd === '0) begin
         bad++; $display("FAIL mid_pending: ready=%b iq_data=%h required ready 0 with a pending word", o_ready, iq_wd);
      end
      #2 rst_n = 1'b0;
      #1 outputs_zero("async_reset_mid_run");
      strobe = 1'b0; iq_full = 1'b0;
      @(posedge clk); #1;
      outputs_zero("held_in_reset");
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_user(6, 10, 1, -1, -1, 0, "after_reset");
   endtask

   initial begin
      test_reset;
      test_basic;
      test_exact_fill;
      test_backpressure;
      test_noise_full_flush;
      test_zero_cases;
      test_reset_mid;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
